// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-fetch request controller: one outstanding word request, tagged pushes into ibex_fetch_fifo.
// Defining FETCH_ERR_EN enables error responses to halt sequential fetch until the next branch.
module ibex_fetch_req_ctrl #(
   parameter int unsigned AddrW = 93
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_i,
   input  logic             branch_i,
   input  logic [AddrW-1:0] branch_addr_i,
   output logic             instr_req_o,
   input  logic             instr_gnt_i,
   output logic [31:0]      instr_addr_o,
   input  logic             instr_rvalid_i,
   input  logic [31:0]      instr_rdata_i,
   input  logic             instr_err_i,
   output logic             fifo_in_valid_o,
   input  logic             fifo_in_ready_i,
   output logic [AddrW-1:0] fifo_in_addr_o,
   output logic [31:0]      fifo_in_rdata_o,
   output logic             fifo_clear_o,
   output logic             fetch_err_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_GNT     = 2'd1,
      WAIT_RVALID  = 2'd2,
      WAIT_ABORTED = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [AddrW-1:0] fetch_addr_q;
   logic [AddrW-1:0] tag_q;
   logic [AddrW-1:0] branch_tag;
   logic [AddrW-1:0] issue_tag;
   logic [AddrW-1:0] next_addr;
   logic             halt;
   logic             resp_err;
   logic             seq_ok;
   logic             issue_c;
   logic             push_c;
   logic             err_c;

`ifdef FETCH_ERR_EN
   logic halt_q;
   assign halt     = halt_q;
   assign resp_err = instr_err_i;
`else
   logic unused_err;
   assign unused_err = instr_err_i;
   assign halt       = 1'b0;
   assign resp_err   = 1'b0;
`endif

   // Branch targets keep bit 1 in the tag so a compressed entry point is visible downstream.
   assign branch_tag = branch_addr_i & ~AddrW'(1);
   assign seq_ok     = req_i & fifo_in_ready_i & ~halt;
   assign issue_tag  = branch_i ? branch_tag : fetch_addr_q;
   assign next_addr  = {issue_tag[AddrW-1:32], issue_tag[31:2] + 30'h1, 2'b00};

   // Next-state, issue and push decisions.
   always_comb begin
      state_d = state_q;
      issue_c = 1'b0;
      push_c  = 1'b0;
      err_c   = 1'b0;
      case (state_q)
         IDLE: begin
            issue_c = branch_i | seq_ok;
         end
         WAIT_GNT: begin
            issue_c = 1'b1;
         end
         WAIT_RVALID: begin
            if (instr_rvalid_i) begin
               if (branch_i) begin
                  issue_c = 1'b1;
               end else if (resp_err) begin
                  err_c   = 1'b1;
                  state_d = IDLE;
               end else begin
                  push_c  = 1'b1;
                  issue_c = seq_ok;
                  state_d = IDLE;
               end
            end else if (branch_i) begin
               state_d = WAIT_ABORTED;
            end
         end
         WAIT_ABORTED: begin
            // The stale response frees the bus; the stored target is issued in the same cycle.
            issue_c = instr_rvalid_i;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (issue_c) begin
         state_d = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         fetch_addr_q <= '0;
         tag_q        <= '0;
      end else begin
         state_q <= state_d;
         if (issue_c && instr_gnt_i) begin
            tag_q        <= issue_tag;
            fetch_addr_q <= next_addr;
         end else if (issue_c || branch_i) begin
            // Holds an ungranted request or remembers a target while a stale response drains.
            fetch_addr_q <= issue_tag;
         end
      end
   end

`ifdef FETCH_ERR_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         halt_q <= 1'b0;
      end else if (branch_i) begin
         halt_q <= 1'b0;
      end else if (err_c) begin
         halt_q <= 1'b1;
      end
   end
`endif

   assign instr_req_o     = issue_c;
   assign instr_addr_o    = {issue_tag[31:2], 2'b00};
   assign fifo_in_valid_o = push_c;
   assign fifo_in_addr_o  = tag_q;
   assign fifo_in_rdata_o = instr_rdata_i;
   assign fifo_clear_o    = branch_i;
   assign fetch_err_o     = err_c;
   assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Scoreboard bench for ibex_fetch_req_ctrl: transaction-level fetch model plus a random-latency memory.
`timescale 1ns/1ps
module tb_ibex_fetch_req_ctrl;
   localparam int unsigned AW = 93;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          req_i = 1'b0;
   logic          branch_i = 1'b0;
   logic [AW-1:0] branch_addr_i = '0;
   logic          instr_req_o;
   logic          instr_gnt_i = 1'b0;
   logic [31:0]   instr_addr_o;
   logic          instr_rvalid_i = 1'b0;
   logic [31:0]   instr_rdata_i = '0;
   logic          instr_err_i = 1'b0;
   logic          fifo_in_valid_o;
   logic          fifo_in_ready_i = 1'b0;
   logic [AW-1:0] fifo_in_addr_o;
   logic [31:0]   fifo_in_rdata_o;
   logic          fifo_clear_o;
   logic          fetch_err_o;
   logic          busy_o;

   ibex_fetch_req_ctrl #(.AddrW(AW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i),
      .branch_addr_i(branch_addr_i), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
      .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
      .instr_err_i(instr_err_i), .fifo_in_valid_o(fifo_in_valid_o), .fifo_in_ready_i(fifo_in_ready_i),
      .fifo_in_addr_o(fifo_in_addr_o), .fifo_in_rdata_o(fifo_in_rdata_o), .fifo_clear_o(fifo_clear_o),
      .fetch_err_o(fetch_err_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic          is_err;
      logic [AW-1:0] tag;
      logic [31:0]   data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] gnt_q[$];
   int          checks = 0;
   int          errors = 0;

   // Reference model: program counter, halt flag and the single memory transaction in flight.
   logic [AW-1:0] pc = '0;
   bit            halted = 1'b0;
   bit            mem_pend = 1'b0;
   bit            mem_stale = 1'b0;
   logic [AW-1:0] mem_tag = '0;
   int            mem_cnt = 0;
   int            lat = 1;
   bit            prev_ungr = 1'b0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   function automatic logic [AW-1:0] next_word(input logic [AW-1:0] a);
      return {a[AW-1:32], a[31:2] + 30'h1, 2'b00};
   endfunction

   // One bus cycle: drive inputs, then advance the model from what happens on the bus.
   task automatic step(input bit b, input logic [AW-1:0] ba, input bit rq, input bit rdy,
                       input bit g, input logic [31:0] rd, input bit e);
      bit   rv;
      exp_t x;
      @(negedge clk_i);
      rv = mem_pend && (mem_cnt == 0);
      if (mem_pend && mem_cnt > 0) mem_cnt--;
      branch_i = b; branch_addr_i = ba; req_i = rq; fifo_in_ready_i = rdy;
      instr_gnt_i = g; instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = e;
      #2;
      chk("busy", 128'(busy_o), 128'(mem_pend || prev_ungr));
      if (b) begin
         pc     = ba & ~AW'(1);
         halted = 1'b0;
         if (mem_pend) mem_stale = 1'b1;
      end
      if (rv) begin
         mem_pend = 1'b0;
         if (!mem_stale && !b) begin
            x.is_err = 1'b0; x.tag = mem_tag; x.data = rd;
`ifdef FETCH_ERR_EN
            if (e) begin
               x.is_err = 1'b1; x.tag = '0; x.data = '0;
               halted = 1'b1;
            end
`endif
            exp_q.push_back(x);
         end
      end
`ifdef FETCH_ERR_EN
      if (halted && !b) chk("halt_no_req", 128'(instr_req_o), 128'(0));
`endif
      if (instr_req_o && g) begin
         chk("one_outstanding", 128'(mem_pend), 128'(0));
         gnt_q.push_back({pc[31:2], 2'b00});
         mem_pend  = 1'b1;
         mem_stale = 1'b0;
         mem_tag   = pc;
         mem_cnt   = lat - 1;
         pc        = next_word(pc);
      end
      prev_ungr = instr_req_o && !g;
   endtask

   // Monitor: pops expectations whenever the DUT pushes, errors or gets a grant.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk_i);
         #3;
         if (!rst_ni) continue;
         chk("clear_eq_branch", 128'(fifo_clear_o), 128'(branch_i));
         chk("push_with_clear", 128'(fifo_in_valid_o & fifo_clear_o), 128'(0));
         chk("push_with_err", 128'(fifo_in_valid_o & fetch_err_o), 128'(0));
         if (fifo_in_valid_o || fetch_err_o) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out valid=%0b err=%0b required none", fifo_in_valid_o, fetch_err_o);
            end else begin
               x = exp_q.pop_front();
               chk("out_kind_err", 128'(fetch_err_o), 128'(x.is_err));
               if (!x.is_err) begin
                  chk("push_tag", 128'(fifo_in_addr_o), 128'(x.tag));
                  chk("push_data", 128'(fifo_in_rdata_o), 128'(x.data));
               end
            end
         end
         if (instr_req_o && instr_gnt_i) begin
            checks++;
            if (gnt_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_gnt addr=%0h required none", instr_addr_o);
            end else begin
               chk("gnt_addr", 128'(instr_addr_o), 128'(gnt_q.pop_front()));
            end
         end
      end
   end

   initial begin
      logic [AW-1:0] ba;
      logic [AW-1:0] up;
      repeat (3) @(negedge clk_i);
      #2;
      chk("rst_req", 128'(instr_req_o), 128'(0));
      chk("rst_addr", 128'(instr_addr_o), 128'(0));
      chk("rst_valid", 128'(fifo_in_valid_o), 128'(0));
      chk("rst_tag", 128'(fifo_in_addr_o), 128'(0));
      chk("rst_err", 128'(fetch_err_o), 128'(0));
      chk("rst_busy", 128'(busy_o), 128'(0));
      rst_ni = 1'b1;

      // Branch to 0x80, single-cycle memory, back-to-back into 0x84.
      lat = 1;
      step(1, AW'(32'h80), 1, 1, 1, 32'h0, 0);
      step(0, '0, 1, 1, 1, 32'h0000_0013, 0);
      step(0, '0, 0, 1, 0, 32'h1111_1111, 0);
      chk("req_low_idle", 128'(instr_req_o), 128'(0));

      // Branch to 0x102: aligned request, tag keeps bit 1.
      step(1, AW'(32'h102), 1, 1, 1, 32'h0, 0);
      step(0, '0, 1, 1, 1, 32'h2222_2222, 0);
      step(0, '0, 0, 1, 0, 32'h3333_3333, 0);

      // FIFO not ready gates sequential issue.
      step(0, '0, 1, 0, 1, 32'h0, 0);
      chk("rdy_gate0", 128'(instr_req_o), 128'(0));
      step(0, '0, 1, 0, 1, 32'h0, 0);
      chk("rdy_gate1", 128'(instr_req_o), 128'(0));
      step(0, '0, 1, 1, 1, 32'h0, 0);
      chk("rdy_resume", 128'(instr_req_o), 128'(1));
      step(0, '0, 0, 1, 0, 32'h4444_4444, 0);

      // Branch while waiting on a slow response; stale word is dropped.
      lat = 4;
      step(1, AW'(32'h180), 1, 1, 1, 32'h0, 0);
      lat = 1;
      step(1, AW'(32'h200), 0, 1, 0, 32'h0, 0);
      chk("abort_clear", 128'(fifo_clear_o), 128'(1));
      for (int i = 0; i < 6; i++) step(0, '0, 0, 1, 1, 32'h5555_0000 + 32'(i), 0);

      // Grant withheld: request and address hold, branch retargets mid-wait.
      for (int i = 0; i < 4; i++) begin
         step(i == 1, AW'(32'h300), 1, 1, 0, 32'h0, 0);
         chk("gnt_hold_req", 128'(instr_req_o), 128'(1));
         chk("gnt_hold_addr", 128'(instr_addr_o), 128'({pc[31:2], 2'b00}));
      end
      chk("retarget_addr", 128'(instr_addr_o), 128'(32'h300));
      step(0, '0, 1, 1, 1, 32'h0, 0);
      step(0, '0, 0, 1, 0, 32'h6666_6666, 0);

      // Error response on the word at 0x84.
      step(1, AW'(32'h80), 1, 1, 1, 32'h0, 0);
      step(0, '0, 1, 1, 1, 32'h7777_7777, 0);
      step(0, '0, 1, 1, 1, 32'h8888_8888, 1);
      for (int i = 0; i < 3; i++) step(0, '0, 1, 1, 1, 32'h9999_0000 + 32'(i), 0);
      step(1, AW'(32'h400), 1, 1, 1, 32'h0, 0);
      for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 1, 32'hAAAA_0000 + 32'(i), 0);

      // Randomized traffic with random upper tag bits and word-address wrap.
      for (int i = 0; i < 3000; i++) begin
         up = AW'({$urandom, $urandom, $urandom});
         ba = ($urandom_range(0, 3) == 0) ? {up[AW-1:32], 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))} : up;
         lat = int'($urandom_range(1, 3));
         step($urandom_range(0, 15) == 0, ba, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 7) == 0);
      end

      lat = 1;
      for (int i = 0; i < 10; i++) step(0, '0, 0, 1, 1, $urandom, 0);
      @(negedge clk_i);
      #4;
      chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
      chk("gnt_q_drained", 128'(gnt_q.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
